// File: rtl/uart_axil_bridge_if.sv
// AXI4-Lite slave bundle carried between a bus master and the UART register bridge.
interface uart_axil_bridge_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/uart_axil_bridge.sv
// AXI4-Lite slave that turns single-outstanding reads/writes into uart_top's
// one-cycle register strobes, reporting register errors as SLVERR.
module uart_axil_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  uart_clk,
  input  logic                  rst_n,
  uart_axil_bridge_if.slave     s_axil,
  output logic [3:0]            reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wen,
  output logic                  reg_ren,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_error
);

  if (ADDR_WIDTH < 4 || DATA_WIDTH != 32) begin : g_bad_cfg
    $error("uart_axil_bridge: ADDR_WIDTH must be >= 4 and DATA_WIDTH must be 32");
  end

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WSTB, WCAP, BRESP, RSTB, RCAP, RRESP} state_e;

  state_e                  state_q, state_d;
  logic                    aw_full_q, w_full_q, ar_full_q;
  logic [3:0]              aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic                    last_wr_q;
  logic [3:0]              reg_addr_q;
  logic [DATA_WIDTH-1:0]   reg_wdata_q, rdata_q;
  logic [1:0]              bresp_q, rresp_q;

  logic wr_pend, rd_pend, grant_wr, grant_rd, wr_bad, rd_bad, b_hs, r_hs;

  assign s_axil.awready = !aw_full_q;
  assign s_axil.wready  = !w_full_q;
  assign s_axil.arready = !ar_full_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;
  assign reg_addr       = reg_addr_q;
  assign reg_wdata      = reg_wdata_q;

  assign b_hs    = s_axil.bvalid & s_axil.bready;
  assign r_hs    = s_axil.rvalid & s_axil.rready;
  assign wr_pend = aw_full_q & w_full_q;
  assign rd_pend = ar_full_q;
  // Partial-word writes and unaligned addresses never reach the register file.
  assign wr_bad  = (aw_addr_q[1:0] != 2'b00) || (w_strb_q != '1);
  assign rd_bad  = (ar_addr_q[1:0] != 2'b00);

  // Capture buffers: each holds one beat until its response handshake.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (s_axil.awvalid && !aw_full_q) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= s_axil.awaddr[3:0];
      end else if (b_hs) begin
        aw_full_q <= 1'b0;
      end
      if (s_axil.wvalid && !w_full_q) begin
        w_full_q <= 1'b1;
        w_data_q <= s_axil.wdata;
        w_strb_q <= s_axil.wstrb;
      end else if (b_hs) begin
        w_full_q <= 1'b0;
      end
      if (s_axil.arvalid && !ar_full_q) begin
        ar_full_q <= 1'b1;
        ar_addr_q <= s_axil.araddr[3:0];
      end else if (r_hs) begin
        ar_full_q <= 1'b0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
    end else begin
      state_q <= state_d;
      // Round-robin pointer only moves when both directions contend.
      if (wr_pend && rd_pend && state_q == IDLE) last_wr_q <= grant_wr;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_pend && rd_pend) begin
          grant_rd = last_wr_q;
          grant_wr = !last_wr_q;
        end else begin
          grant_wr = wr_pend;
          grant_rd = rd_pend;
        end
        if (grant_wr)      state_d = wr_bad ? BRESP : WSTB;
        else if (grant_rd) state_d = rd_bad ? RRESP : RSTB;
      end
      WSTB:    state_d = WCAP;
      WCAP:    state_d = BRESP;
      BRESP:   if (s_axil.bready) state_d = IDLE;
      RSTB:    state_d = RCAP;
      RCAP:    state_d = RRESP;
      RRESP:   if (s_axil.rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    reg_wen       = 1'b0;
    reg_ren       = 1'b0;
    s_axil.bvalid = 1'b0;
    s_axil.rvalid = 1'b0;
    unique case (state_q)
      WSTB:    reg_wen       = 1'b1;
      RSTB:    reg_ren       = 1'b1;
      BRESP:   s_axil.bvalid = 1'b1;
      RRESP:   s_axil.rvalid = 1'b1;
      default: ;
    endcase
  end

  // Register-side address/data and AXI response payloads; all hold between updates.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      bresp_q     <= RESP_OKAY;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
    end else begin
      if (grant_wr) begin
        if (wr_bad) begin
          bresp_q <= RESP_SLVERR;
        end else begin
          reg_addr_q  <= aw_addr_q;
          reg_wdata_q <= w_data_q;
        end
      end
      if (grant_rd) begin
        if (rd_bad) begin
          rresp_q <= RESP_SLVERR;
          rdata_q <= '0;
        end else begin
          reg_addr_q <= ar_addr_q;
        end
      end
      // reg_rdata / reg_error are valid the cycle after the strobe.
      if (state_q == WCAP) bresp_q <= reg_error ? RESP_SLVERR : RESP_OKAY;
      if (state_q == RCAP) begin
        rdata_q <= reg_rdata;
        rresp_q <= reg_error ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_uart_axil_bridge.sv
// Directed bench for uart_axil_bridge: latency, responses, arbitration, reset abort.
module tb_uart_axil_bridge;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_axil_bridge_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata = 32'h0;
  logic        reg_wen, reg_ren;
  logic        reg_error = 1'b0;
  logic [31:0] model_rdata = 32'h0;
  logic        model_err   = 1'b0;

  uart_axil_bridge #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .uart_clk  (clk),
    .rst_n     (rst_n),
    .s_axil    (bus.slave),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wen   (reg_wen),
    .reg_ren   (reg_ren),
    .reg_rdata (reg_rdata),
    .reg_error (reg_error)
  );

  // Register-file stand-in: answers only in the cycle after a strobe, junk otherwise.
  always @(posedge clk) begin
    if (reg_wen || reg_ren) begin
      reg_rdata <= model_rdata;
      reg_error <= model_err;
    end else begin
      reg_rdata <= 32'hDEAD_BEEF;
      reg_error <= 1'b1;
    end
  end

  int          wen_cnt = 0, ren_cnt = 0, wen_cyc = -1, ren_cyc = -1, bad_strobe = 0;
  logic [3:0]  wen_addr = 4'h0, ren_addr = 4'h0;
  logic [31:0] wen_data = 32'h0;
  logic        prev_stb = 1'b0;
  always @(negedge clk) begin
    if (reg_wen) begin
      wen_cnt  <= wen_cnt + 1;
      wen_cyc  <= cyc;
      wen_addr <= reg_addr;
      wen_data <= reg_wdata;
    end
    if (reg_ren) begin
      ren_cnt  <= ren_cnt + 1;
      ren_cyc  <= cyc;
      ren_addr <= reg_addr;
    end
    if ((reg_wen && reg_ren) || ((reg_wen || reg_ren) && prev_stb)) bad_strobe <= bad_strobe + 1;
    prev_stb <= reg_wen | reg_ren;
  end

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int n, output int bc, output logic [1:0] br);
    @(negedge clk);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata  = d; bus.wstrb   = s; bus.wvalid = 1'b1; bus.bready = 1'b1;
    n = cyc;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bc = -1; br = 2'bxx;
    for (int i = 0; i < 20 && bc < 0; i++) begin
      if (bus.bvalid) begin bc = cyc; br = bus.bresp; end
      else @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic do_read(input logic [11:0] a, output int n, output int rc,
                         output logic [31:0] rd, output logic [1:0] rr);
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = cyc;
    @(negedge clk);
    bus.arvalid = 1'b0;
    rc = -1; rd = 32'hx; rr = 2'bxx;
    for (int i = 0; i < 20 && rc < 0; i++) begin
      if (bus.rvalid) begin rc = cyc; rd = bus.rdata; rr = bus.rresp; end
      else @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin miss++;
      $display("FAIL reset_ready: got %b expected 111", {bus.awready, bus.wready, bus.arready}); end
    vec++; if ({bus.bvalid, bus.rvalid, reg_wen, reg_ren} !== 4'b0000) begin miss++;
      $display("FAIL reset_valids: got %b expected 0000", {bus.bvalid, bus.rvalid, reg_wen, reg_ren}); end
    vec++; if ({bus.bresp, bus.rresp} !== 4'b0000) begin miss++;
      $display("FAIL reset_resp: got %b expected 0000", {bus.bresp, bus.rresp}); end
    vec++; if (bus.rdata !== 32'h0) begin miss++;
      $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    vec++; if ({reg_addr, reg_wdata} !== 36'h0) begin miss++;
      $display("FAIL reset_regbus: got %h/%h expected 0/0", reg_addr, reg_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_aligned_write;
    int n, bc, wc0; logic [1:0] br;
    model_err = 1'b0; wc0 = wen_cnt;
    do_write(12'h004, 32'h0000_00A5, 4'hF, n, bc, br);
    vec++; if (bc !== n + 4) begin miss++; $display("FAIL aw_bvalid_cycle: got %0d expected %0d", bc, n + 4); end
    vec++; if (br !== 2'b00) begin miss++; $display("FAIL aw_bresp: got %b expected 00", br); end
    vec++; if (wen_cnt - wc0 !== 1) begin miss++; $display("FAIL aw_wen_count: got %0d expected 1", wen_cnt - wc0); end
    vec++; if (wen_cyc !== n + 2) begin miss++; $display("FAIL aw_wen_cycle: got %0d expected %0d", wen_cyc, n + 2); end
    vec++; if ({wen_addr, wen_data} !== {4'h4, 32'hA5}) begin miss++;
      $display("FAIL aw_wen_payload: got %h/%h expected 4/a5", wen_addr, wen_data); end
    vec++; if ({reg_addr, reg_wdata} !== {4'h4, 32'hA5}) begin miss++;
      $display("FAIL aw_reg_hold: got %h/%h expected 4/a5", reg_addr, reg_wdata); end
    vec++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin miss++;
      $display("FAIL aw_after_b: got %b expected 011", {bus.bvalid, bus.awready, bus.wready}); end
  endtask

  task automatic test_staggered_write;
    int n, bc, wc0;
    model_err = 1'b0; wc0 = wen_cnt;
    @(negedge clk);
    bus.wdata = 32'h0000_003C; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
    @(negedge clk);
    bus.wvalid = 1'b0;
    vec++; if ({bus.awready, bus.wready} !== 2'b10) begin miss++;
      $display("FAIL stag_w_only: got %b expected 10", {bus.awready, bus.wready}); end
    @(negedge clk);
    @(negedge clk);
    bus.awaddr = 12'h00C; bus.awvalid = 1'b1; n = cyc;
    @(negedge clk);
    bus.awvalid = 1'b0;
    vec++; if ({bus.awready, bus.wready} !== 2'b00) begin miss++;
      $display("FAIL stag_both_full: got %b expected 00", {bus.awready, bus.wready}); end
    bc = -1;
    for (int i = 0; i < 20 && bc < 0; i++) begin
      if (bus.bvalid) bc = cyc; else @(negedge clk);
    end
    vec++; if (bc !== n + 4) begin miss++; $display("FAIL stag_bvalid_cycle: got %0d expected %0d", bc, n + 4); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec++; if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b1_00_00) begin miss++;
        $display("FAIL stag_hold_%0d: got %b expected 10000", i, {bus.bvalid, bus.bresp, bus.awready, bus.wready}); end
    end
    bus.bready = 1'b1;
    @(negedge clk);
    vec++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin miss++;
      $display("FAIL stag_release: got %b expected 011", {bus.bvalid, bus.awready, bus.wready}); end
    vec++; if (wen_cnt - wc0 !== 1) begin miss++; $display("FAIL stag_wen_count: got %0d expected 1", wen_cnt - wc0); end
    vec++; if ({wen_addr, wen_data} !== {4'hC, 32'h3C}) begin miss++;
      $display("FAIL stag_payload: got %h/%h expected c/3c", wen_addr, wen_data); end
  endtask

  task automatic test_read;
    int n, rc, rc0; logic [31:0] rd; logic [1:0] rr;
    model_rdata = 32'h1234_0055; model_err = 1'b0; rc0 = ren_cnt;
    do_read(12'h008, n, rc, rd, rr);
    vec++; if (rc !== n + 4) begin miss++; $display("FAIL rd_rvalid_cycle: got %0d expected %0d", rc, n + 4); end
    vec++; if (rd !== 32'h1234_0055) begin miss++; $display("FAIL rd_rdata: got %h expected 12340055", rd); end
    vec++; if (rr !== 2'b00) begin miss++; $display("FAIL rd_rresp: got %b expected 00", rr); end
    vec++; if (ren_cyc !== n + 2) begin miss++; $display("FAIL rd_ren_cycle: got %0d expected %0d", ren_cyc, n + 2); end
    vec++; if ({ren_addr, ren_cnt - rc0} !== {4'h8, 32'd1}) begin miss++;
      $display("FAIL rd_ren: got addr %h count %0d expected 8/1", ren_addr, ren_cnt - rc0); end
    model_err = 1'b1;
    do_read(12'h008, n, rc, rd, rr);
    vec++; if (rr !== 2'b10) begin miss++; $display("FAIL rd_err_rresp: got %b expected 10", rr); end
    vec++; if (rc !== n + 4) begin miss++; $display("FAIL rd_err_cycle: got %0d expected %0d", rc, n + 4); end
    model_err = 1'b0;
  endtask

  task automatic test_errors;
    int n, bc, rc, wc0, rc0; logic [1:0] br, rr; logic [31:0] rd;
    wc0 = wen_cnt; rc0 = ren_cnt;
    do_write(12'h006, 32'h0000_00FF, 4'hF, n, bc, br);
    vec++; if (br !== 2'b10) begin miss++; $display("FAIL err_misalign_bresp: got %b expected 10", br); end
    vec++; if (bc !== n + 2) begin miss++; $display("FAIL err_misalign_cycle: got %0d expected %0d", bc, n + 2); end
    do_write(12'h004, 32'h0000_00EE, 4'h3, n, bc, br);
    vec++; if (br !== 2'b10) begin miss++; $display("FAIL err_strb_bresp: got %b expected 10", br); end
    vec++; if (bc !== n + 2) begin miss++; $display("FAIL err_strb_cycle: got %0d expected %0d", bc, n + 2); end
    vec++; if (wen_cnt - wc0 !== 0) begin miss++; $display("FAIL err_no_wen: got %0d expected 0", wen_cnt - wc0); end
    vec++; if (reg_wdata !== 32'h3C) begin miss++; $display("FAIL err_wdata_hold: got %h expected 3c", reg_wdata); end
    do_read(12'h001, n, rc, rd, rr);
    vec++; if ({rr, rd} !== {2'b10, 32'h0}) begin miss++;
      $display("FAIL err_rd_resp: got %b/%h expected 10/0", rr, rd); end
    vec++; if (rc !== n + 2) begin miss++; $display("FAIL err_rd_cycle: got %0d expected %0d", rc, n + 2); end
    vec++; if (ren_cnt - rc0 !== 0) begin miss++; $display("FAIL err_no_ren: got %0d expected 0", ren_cnt - rc0); end
  endtask

  task automatic drive_both(input logic [11:0] wa, input logic [31:0] wd, input logic [11:0] ra, output int n);
    @(negedge clk);
    bus.awaddr = wa; bus.awvalid = 1'b1; bus.wdata = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = ra; bus.arvalid = 1'b1; bus.bready = 1'b1; bus.rready = 1'b1;
    n = cyc;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
  endtask

  task automatic test_arbitration;
    int n, bc, rc; logic [31:0] rd;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    model_rdata = 32'h0000_0077; model_err = 1'b0;
    drive_both(12'h000, 32'h11, 12'h004, n);
    bc = -1; rc = -1; rd = 32'h0;
    for (int i = 0; i < 30 && bc < 0; i++) begin
      @(negedge clk);
      if (bus.rvalid && rc < 0) begin rc = cyc; rd = bus.rdata; end
      if (bus.bvalid) bc = cyc;
    end
    vec++; if ({ren_cyc, rc} !== {n + 2, n + 4}) begin miss++;
      $display("FAIL arb1_read_first: got ren %0d rvalid %0d expected %0d/%0d", ren_cyc, rc, n + 2, n + 4); end
    vec++; if ({wen_cyc, bc} !== {n + 6, n + 8}) begin miss++;
      $display("FAIL arb1_write_second: got wen %0d bvalid %0d expected %0d/%0d", wen_cyc, bc, n + 6, n + 8); end
    vec++; if (rd !== 32'h77) begin miss++; $display("FAIL arb1_rdata: got %h expected 77", rd); end
    @(negedge clk);
    model_rdata = 32'h0000_0088;
    drive_both(12'h008, 32'h22, 12'h00C, n);
    bc = -1; rc = -1;
    for (int i = 0; i < 30 && rc < 0; i++) begin
      @(negedge clk);
      if (bus.bvalid && bc < 0) bc = cyc;
      if (bus.rvalid) begin rc = cyc; rd = bus.rdata; end
    end
    vec++; if ({wen_cyc, bc} !== {n + 2, n + 4}) begin miss++;
      $display("FAIL arb2_write_first: got wen %0d bvalid %0d expected %0d/%0d", wen_cyc, bc, n + 2, n + 4); end
    vec++; if ({ren_cyc, rc} !== {n + 6, n + 8}) begin miss++;
      $display("FAIL arb2_read_second: got ren %0d rvalid %0d expected %0d/%0d", ren_cyc, rc, n + 6, n + 8); end
    vec++; if ({wen_data, rd} !== {32'h22, 32'h88}) begin miss++;
      $display("FAIL arb2_data: got %h/%h expected 22/88", wen_data, rd); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n; logic found, seen;
    @(negedge clk);
    bus.awaddr = 12'h008; bus.awvalid = 1'b1; bus.wdata = 32'h99; bus.wstrb = 4'hF;
    bus.wvalid = 1'b1; bus.bready = 1'b1; n = cyc;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (reg_wen) found = 1'b1;
    end
    vec++; if (found !== 1'b1) begin miss++; $display("FAIL rst_mid_wstb: got %b expected 1", found); end
    rst_n = 1'b0;
    #1;
    vec++; if ({reg_wen, reg_ren, reg_addr, reg_wdata} !== 38'h0) begin miss++;
      $display("FAIL rst_mid_regbus: got %b%b/%h/%h expected 0", reg_wen, reg_ren, reg_addr, reg_wdata); end
    vec++; if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin miss++;
      $display("FAIL rst_mid_axi: got %b expected 11100", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.bvalid || reg_wen) seen = 1'b1;
    end
    vec++; if (seen !== 1'b0) begin miss++; $display("FAIL rst_mid_no_resp: got %b expected 0", seen); end
    vec++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin miss++;
      $display("FAIL rst_mid_ready: got %b expected 111", {bus.awready, bus.wready, bus.arready}); end
  endtask

  task automatic test_strobe_rules;
    vec++; if (bad_strobe !== 0) begin miss++;
      $display("FAIL strobe_rules: got %0d violations expected 0", bad_strobe); end
  endtask

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    test_reset();
    test_aligned_write();
    test_staggered_write();
    test_read();
    test_errors();
    test_arbitration();
    test_reset_mid();
    test_strobe_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
